ps2_key_decoder: RTL and testbench

Receives the raw PS/2 keyboard line (ps2_clk/ps2_data), deframes 11-bit PS/2 frames, decodes Set-2 make/break sequences including the E0 extended prefix, and produces per-key event pulses plus a held-key level for one configured key. It sits directly upstream of the key-latched random generator. Its `keyPressed` level drives that block's `rise` input, so each physical press latches exactly one random value, with typematic repeats suppressed.

---
 rtl/ps2_key_decoder_if.sv | 31 +++
 rtl/ps2_key_decoder.sv | 165 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard pins and decoded key events.
// The decoder is the slave; the keyboard side is the master.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;
    logic       keyPressed;
    logic       frameErr;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyCode,
        input  make,
        input  brake,
        input  keyPressed,
        input  frameErr
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyCode,
        output make,
        output brake,
        output keyPressed,
        output frameErr
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 receiver: deframes bytes, decodes E0/F0 sequences,
// emits make/brake pulses and a held level for one tracked key.
module ps2_key_decoder #(
    parameter logic [8:0] KEY_CODE       = 9'h05A,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          resetN,
    ps2_key_decoder_if.slave bus
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] TO = WDW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic           r_clk_s1;
    logic           r_clk_s2;
    logic           r_clk_prev;
    logic           r_dat_s1;
    logic           r_dat_s2;
    logic           w_fe;

    state_t         r_state;
    logic [7:0]     r_shift;
    logic [2:0]     r_bitcnt;
    logic           r_par_ok;
    logic [WDW-1:0] r_wd;
    logic           r_byte_valid;
    logic           r_frame_err;

    logic           r_ext;
    logic           r_brk;
    logic [8:0]     r_key_code;
    logic           r_make;
    logic           r_brake;
    logic           r_key_pressed;
    logic [8:0]     w_code;

    assign w_fe   = r_clk_prev & ~r_clk_s2;
    assign w_code = {r_ext, r_shift};

    assign bus.keyCode    = r_key_code;
    assign bus.make       = r_make;
    assign bus.brake      = r_brake;
    assign bus.keyPressed = r_key_pressed;
    assign bus.frameErr   = r_frame_err;

    // Two-flop synchronizers plus a delayed clock copy for edge detect.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= bus.ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Frame FSM with watchdog; yields one-cycle byte or error strobes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_par_ok     <= 1'b0;
            r_wd         <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fe) begin
                r_wd <= '0;
                unique case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_shift  <= '0;
                            r_bitcnt <= '0;
                            r_state  <= S_DATA;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shift, r_dat_s2};
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        if (r_par_ok && r_dat_s2)
                            r_byte_valid <= 1'b1;
                        else
                            r_frame_err <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_wd >= TO) begin
                    r_state     <= S_IDLE;
                    r_frame_err <= 1'b1;
                    r_wd        <= '0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end else begin
                r_wd <= '0;
            end
        end
    end

    // Prefix tracking and event generation; errors discard prefixes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_key_code    <= '0;
            r_make        <= 1'b0;
            r_brake       <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_make  <= 1'b0;
            r_brake <= 1'b0;
            if (r_frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_byte_valid) begin
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_key_code <= w_code;
                    if (r_brk) begin
                        r_brake <= 1'b1;
                        if (w_code == KEY_CODE)
                            r_key_pressed <= 1'b0;
                    end else begin
                        r_make <= 1'b1;
                        if (w_code == KEY_CODE)
                            r_key_pressed <= 1'b1;
                    end
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: table of frames with hand-written
// expected events, scoreboard queue, plus timeout/reset sequences.
module tb_ps2_key_decoder;
    localparam int TOC  = 400;
    localparam int HALF = 40;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_MAKE = 2'd1;
    localparam logic [1:0] K_BRK  = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [8:0] code;
        logic       kp;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        logic       perr;
        logic       serr;
        logic [1:0] kind;
        logic [8:0] code;
        logic       kp;
    } vec_t;

    logic clk;
    logic resetN;
    int   tests;
    int   fails;
    ev_t  q[$];

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .KEY_CODE      (9'h05A),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [10:0] bits,
                            input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            wait_clk(HALF);
            bus.ps2_clk = 1'b0;
            wait_clk(HALF);
            bus.ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input logic perr,
                              input logic serr);
        logic p;
        p = ~(^b) ^ perr;
        send_raw({~serr, p, b, 1'b0}, 11);
        bus.ps2_data = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic push(input logic [1:0] k,
                        input logic [8:0] c,
                        input logic kp);
        ev_t e;
        e.kind = k;
        e.code = c;
        e.kp   = kp;
        if (k != K_NONE)
            q.push_back(e);
    endtask

    // Scoreboard monitor: pops one expectation per output event.
    always @(negedge clk) begin
        logic [1:0] act;
        ev_t        e;
        if (resetN) begin
            if (bus.make || bus.brake || bus.frameErr) begin
                chk("one_event_at_a_time",
                    32'(bus.make) + 32'(bus.brake)
                    + 32'(bus.frameErr), 32'd1);
                act = bus.frameErr ? K_ERR :
                      bus.make ? K_MAKE : K_BRK;
                if (q.size() == 0) begin
                    chk("unexpected_event", 32'(act), 32'(K_NONE));
                end else begin
                    e = q.pop_front();
                    chk("event_kind", 32'(act), 32'(e.kind));
                    if (e.kind != K_ERR) begin
                        chk("keyCode", 32'(bus.keyCode),
                            32'(e.code));
                        chk("keyPressed", 32'(bus.keyPressed),
                            32'(e.kp));
                    end
                end
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_keyCode"}, 32'(bus.keyCode), 32'd0);
        chk({tag, "_make"}, 32'(bus.make), 32'd0);
        chk({tag, "_brake"}, 32'(bus.brake), 32'd0);
        chk({tag, "_keyPressed"}, 32'(bus.keyPressed), 32'd0);
        chk({tag, "_frameErr"}, 32'(bus.frameErr), 32'd0);
    endtask

    task automatic chk_drained(input string nm);
        chk(nm, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    vec_t vt[21];

    initial begin
        tests = 0;
        fails = 0;
        vt[0]  = '{8'h1C, 0, 0, K_MAKE, 9'h01C, 0};
        vt[1]  = '{8'hF0, 0, 0, K_NONE, 9'h000, 0};
        vt[2]  = '{8'h1C, 0, 0, K_BRK,  9'h01C, 0};
        vt[3]  = '{8'h5A, 0, 0, K_MAKE, 9'h05A, 1};
        vt[4]  = '{8'h5A, 0, 0, K_MAKE, 9'h05A, 1};
        vt[5]  = '{8'h5A, 0, 0, K_MAKE, 9'h05A, 1};
        vt[6]  = '{8'hF0, 0, 0, K_NONE, 9'h000, 0};
        vt[7]  = '{8'h5A, 0, 0, K_BRK,  9'h05A, 0};
        vt[8]  = '{8'hE0, 0, 0, K_NONE, 9'h000, 0};
        vt[9]  = '{8'h75, 0, 0, K_MAKE, 9'h175, 0};
        vt[10] = '{8'hE0, 0, 0, K_NONE, 9'h000, 0};
        vt[11] = '{8'hF0, 0, 0, K_NONE, 9'h000, 0};
        vt[12] = '{8'h75, 0, 0, K_BRK,  9'h175, 0};
        vt[13] = '{8'h1C, 1, 0, K_ERR,  9'h000, 0};
        vt[14] = '{8'hF0, 0, 1, K_ERR,  9'h000, 0};
        vt[15] = '{8'h1C, 0, 0, K_MAKE, 9'h01C, 0};
        vt[16] = '{8'hE0, 0, 0, K_NONE, 9'h000, 0};
        vt[17] = '{8'h1C, 1, 0, K_ERR,  9'h000, 0};
        vt[18] = '{8'h5A, 0, 0, K_MAKE, 9'h05A, 1};
        vt[19] = '{8'hF0, 0, 0, K_NONE, 9'h000, 0};
        vt[20] = '{8'h5A, 0, 0, K_BRK,  9'h05A, 0};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        resetN       = 1'b0;
        wait_clk(5);
        chk_idle_outputs("reset");
        resetN = 1'b1;
        wait_clk(100);
        chk_idle_outputs("post_reset");

        foreach (vt[i]) begin
            push(vt[i].kind, vt[i].code, vt[i].kp);
            send_frame(vt[i].b, vt[i].perr, vt[i].serr);
            chk_drained("table_events_seen");
        end

        push(K_ERR, 9'h000, 1'b0);
        send_raw(11'h000, 5);
        wait_clk(TOC + 200);
        chk_drained("timeout_err_seen");
        push(K_MAKE, 9'h05A, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b0);
        chk_drained("after_timeout_make");
        chk("held_after_timeout", 32'(bus.keyPressed), 32'd1);

        send_raw(11'h000, 3);
        resetN = 1'b0;
        #1;
        chk("midreset_keyPressed", 32'(bus.keyPressed), 32'd0);
        chk("midreset_keyCode", 32'(bus.keyCode), 32'd0);
        bus.ps2_data = 1'b1;
        wait_clk(5);
        resetN = 1'b1;
        wait_clk(100);
        chk_idle_outputs("after_midreset");
        push(K_MAKE, 9'h01C, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk_drained("after_midreset_make");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
